vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 The block SHALL provide the following parameters:
- CLK_DIV, default 4: clk cycles per pixel; legal values are 1 or more.
- H_ACTIVE, default 640: visible pixels per line.
- H_FP, default 16: horizontal front porch, in pixels.
- H_SYNC, default 96: hsync width, in pixels.
- H_BP, default 48: horizontal back porch, in pixels.
- V_ACTIVE, default 480: visible lines per frame.
- V_FP, default 10: vertical front porch, in lines.
- V_SYNC, default 2: vsync width, in lines.
- V_BP, default 33: vertical back porch, in lines.
- H_POL, default 0: hsync asserted level (0 = active-low).
- V_POL, default 0: vsync asserted level (0 = active-low).
- CNT_W, default 10: width of pixel_x and pixel_y.
REQ-003 The block SHALL have the following ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- en, input, 1: timing advance enable.
- pixel_tick, output, 1: one-clk pulse for each pixel period.
- hsync, output, 1: horizontal sync, at the level set by H_POL.
- vsync, output, 1: vertical sync, at the level set by V_POL.
- video_on, output, 1: current pixel is in the visible area.
- pixel_x, output, CNT_W: horizontal count.
- pixel_y, output, CNT_W: vertical count.
- line_start, output, 1: one-clk pulse when pixel_x wraps to 0.
- frame_start, output, 1: one-clk pulse when (pixel_x, pixel_y) wraps to (0,0).

Function
REQ-004 The block SHALL compute H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; CNT_W SHALL hold H_TOTAL-1 and V_TOTAL-1. Illegal parameter values are unsupported.
REQ-005 The divider counter SHALL count 0..CLK_DIV-1 while en=1 and wrap to 0; pixel_tick SHALL be 1 in the clk cycle where divider==CLK_DIV-1 and en=1; with CLK_DIV=1, pixel_tick SHALL equal en.
REQ-006 On a clk edge with pixel_tick=1, pixel_x SHALL increment, wrapping H_TOTAL-1 -> 0.
REQ-007 On a pixel_tick edge where pixel_x==H_TOTAL-1, pixel_y SHALL increment, wrapping V_TOTAL-1 -> 0; otherwise pixel_y SHALL hold.
REQ-008 The outputs hsync, vsync and video_on SHALL be registered, computed from next-state counter values, so they are cycle-aligned with pixel_x and pixel_y with zero skew.
REQ-009 hsync SHALL equal H_POL when H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1, and ~H_POL otherwise.
REQ-010 vsync SHALL equal V_POL when V_ACTIVE+V_FP <= pixel_y <= V_ACTIVE+V_FP+V_SYNC-1, and ~V_POL otherwise.
REQ-011 video_on SHALL be 1 if and only if pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-012 line_start SHALL be 1 for exactly the one clk cycle following the edge on which pixel_x became 0 through a wrap; frame_start SHALL be 1 in that same cycle when pixel_y also wrapped to 0.
REQ-013 While en=0, the divider, both counters and all sync and video outputs SHALL hold their values, and pixel_tick, line_start and frame_start SHALL be 0; when en returns to 1, counting SHALL resume from the held divider value with no lost or extra pixels.
REQ-014 Arithmetic SHALL be unsigned; the counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-015 On a clk edge with rst=1, the following values SHALL be set, and rst SHALL override en:
- divider=0, pixel_x=0, pixel_y=0;
- hsync=~H_POL, vsync=~V_POL;
- video_on=1;
- pixel_tick=0, line_start=0, frame_start=0.
REQ-016 Reset asserted mid-frame SHALL take effect on the next clk edge, and no partial-frame pulse SHALL follow it.
REQ-017 The first frame_start after reset SHALL occur only at the first full-frame wrap.

Verification
REQ-018 Defaults, rst held for 3 cycles, then en=1 -> reset values hold throughout; pixel_tick occurs every 4th clk; pixel_x reaches 1 after 4 clk.
REQ-019 Defaults -> hsync is low exactly for pixel_x 656..751, which is 96 ticks or 384 clk; video_on falls at pixel_x=640 and rises at pixel_x=0.
REQ-020 Defaults -> consecutive frame_start pulses are 1,680,000 clk apart (800*525*4); vsync is low for pixel_y 490..491, which is 6400 clk.
REQ-021 CLK_DIV=1, H_POL=1, V_POL=1 -> pixel_tick stays at 1; hsync is high for pixel_x 656..751; line_start pulses every 800 clk.
REQ-022 With en=0 for 37 clk mid-line at pixel_x=300 -> all counters and outputs are frozen and there are no pulses; after resume, the next line_start arrives 37 clk later than nominal.
REQ-023 rst pulsed at pixel_y=491, pixel_x=700 -> on the next edge, counters read (0,0), hsync and vsync are inactive, and there is no frame_start pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus horizontal/vertical raster counters with registered sync and blanking
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic HP = H_POL[0];
    localparam logic VP = V_POL[0];

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_x, r_y;
    logic             r_hs, r_vs, r_vid, r_ls, r_fs;
    logic             w_tick, w_hwrap, w_vwrap;
    logic [DIV_W-1:0] w_ndiv;
    logic [CNT_W-1:0] w_nx, w_ny;

    // next-state counters; sync/blank outputs are decoded from these so they line up with the counters
    always_comb begin
        w_tick  = en && (r_div == DIV_MAX);
        w_hwrap = (r_x == H_MAX);
        w_vwrap = (r_y == V_MAX);
        w_ndiv  = en ? ((r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1)) : r_div;
        w_nx    = w_tick ? (w_hwrap ? '0 : r_x + CNT_W'(1)) : r_x;
        w_ny    = (w_tick && w_hwrap) ? (w_vwrap ? '0 : r_y + CNT_W'(1)) : r_y;
    end

    // counter, sync, blanking and wrap-pulse registers; rst overrides en
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_hs  <= ~HP;
            r_vs  <= ~VP;
            r_vid <= 1'b1;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_div <= w_ndiv;
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_hs  <= (w_nx >= HS_BEG && w_nx <= HS_END) ? HP : ~HP;
            r_vs  <= (w_ny >= VS_BEG && w_ny <= VS_END) ? VP : ~VP;
            r_vid <= (w_nx < H_VIS) && (w_ny < V_VIS);
            r_ls  <= w_tick && w_hwrap;
            r_fs  <= w_tick && w_hwrap && w_vwrap;
        end
    end

    assign pixel_tick  = w_tick;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign video_on    = r_vid;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
endmodule
